// File: rtl/cpu_sequencer_if.sv
// Control bundle between the VeriRisc sequencer and the datapath it steers.
// The slave side is the sequencer; the master side drives opcode/flags/run/resume.
interface cpu_sequencer_if #(
    parameter int OPW = 3,
    parameter int PHW = 3
);
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           run;
    logic           resume;
    logic           sel;
    logic           rd;
    logic           ld_ir;
    logic           inc_pc;
    logic           ld_pc;
    logic           ld_ac;
    logic           wr;
    logic           data_e;
    logic           halt;
    logic [PHW-1:0] phase;

    modport slave (
        input  opcode, zero, run, resume,
        output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );

    modport master (
        output opcode, zero, run, resume,
        input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, phase
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Eight-phase fetch/execute sequencer for VeriRisc with stall, halt latching and resume.
// Outputs are a combinational decode of the phase register and halted flag.
module cpu_sequencer #(
    parameter int OPW = 3,
    parameter int PHW = 3
) (
    input  logic             clk,
    input  logic             rst,
    cpu_sequencer_if.slave   bus
);
    localparam logic [OPW-1:0] HLT = 3'd0;
    localparam logic [OPW-1:0] SKZ = 3'd1;
    localparam logic [OPW-1:0] ADD = 3'd2;
    localparam logic [OPW-1:0] AND = 3'd3;
    localparam logic [OPW-1:0] XOR = 3'd4;
    localparam logic [OPW-1:0] LDA = 3'd5;
    localparam logic [OPW-1:0] STO = 3'd6;
    localparam logic [OPW-1:0] JMP = 3'd7;

    localparam logic [PHW-1:0] INST_ADDR  = 3'd0;
    localparam logic [PHW-1:0] INST_FETCH = 3'd1;
    localparam logic [PHW-1:0] INST_LOAD  = 3'd2;
    localparam logic [PHW-1:0] IDLE       = 3'd3;
    localparam logic [PHW-1:0] OP_ADDR    = 3'd4;
    localparam logic [PHW-1:0] OP_FETCH   = 3'd5;
    localparam logic [PHW-1:0] ALU_OP     = 3'd6;
    localparam logic [PHW-1:0] STORE      = 3'd7;

    logic [PHW-1:0] phase_q;
    logic           halted_q;
    logic           aluop;
    logic           is_hlt;

    always_comb begin
        aluop  = (bus.opcode == ADD) || (bus.opcode == AND) ||
                 (bus.opcode == XOR) || (bus.opcode == LDA);
        is_hlt = (bus.opcode == HLT);
    end

    // Halt entry freezes the phase at OP_ADDR; resume restarts at a fresh fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= INST_ADDR;
            halted_q <= 1'b0;
        end else if (halted_q) begin
            if (bus.resume) begin
                halted_q <= 1'b0;
                phase_q  <= INST_ADDR;
            end
        end else if (bus.run) begin
            if (phase_q == OP_ADDR && is_hlt) begin
                halted_q <= 1'b1;
            end else begin
                phase_q <= phase_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.sel    = 1'b0;
        bus.rd     = 1'b0;
        bus.ld_ir  = 1'b0;
        bus.inc_pc = 1'b0;
        bus.ld_pc  = 1'b0;
        bus.ld_ac  = 1'b0;
        bus.wr     = 1'b0;
        bus.data_e = 1'b0;
        bus.halt   = 1'b0;
        bus.phase  = phase_q;
        if (halted_q) begin
            bus.halt   = 1'b1;
            bus.inc_pc = bus.resume;
        end else begin
            case (phase_q)
                INST_ADDR:  bus.sel = 1'b1;
                INST_FETCH: begin bus.sel = 1'b1; bus.rd = 1'b1; end
                INST_LOAD:  begin bus.sel = 1'b1; bus.rd = 1'b1; bus.ld_ir = 1'b1; end
                IDLE:       begin bus.sel = 1'b1; bus.rd = 1'b1; end
                OP_ADDR:    begin bus.halt = is_hlt; bus.inc_pc = !is_hlt; end
                OP_FETCH:   bus.rd = aluop;
                ALU_OP: begin
                    bus.rd     = aluop;
                    bus.inc_pc = (bus.opcode == SKZ) && bus.zero;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.data_e = (bus.opcode == STO);
                end
                STORE: begin
                    bus.rd     = aluop;
                    bus.ld_ac  = aluop;
                    bus.ld_pc  = (bus.opcode == JMP);
                    bus.wr     = (bus.opcode == STO);
                    bus.data_e = (bus.opcode == STO);
                end
                default: bus.sel = 1'b0;
            endcase
            // A stall must not repeat a strobe; levels stay put.
            if (!bus.run) begin
                bus.ld_ir  = 1'b0;
                bus.inc_pc = 1'b0;
                bus.ld_pc  = 1'b0;
                bus.ld_ac  = 1'b0;
                bus.wr     = 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed plus randomized bench for cpu_sequencer against a rule-level reference model.
module tb_cpu_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    int   m_ph = 0;
    bit   m_halted = 1'b0;
    int   n_ld_ir, n_inc, n_ld_ac, n_wr, n_ld_pc;

    cpu_sequencer_if bus ();

    cpu_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit order: sel rd ld_ir inc_pc ld_pc ld_ac wr data_e halt
    function automatic logic [8:0] model_out(input int ph, input bit hlt_st, input int op,
                                             input bit z, input bit r, input bit res);
        bit alu, sel, rd, ld_ir, inc, ld_pc, ld_ac, wr, de, hl;
        if (hlt_st) return {3'b000, res, 4'b0000, 1'b1};
        alu   = (op >= 2) && (op <= 5);
        sel   = ph < 4;
        rd    = (ph >= 1 && ph <= 3) || (ph >= 5 && alu);
        ld_ir = ph == 2;
        inc   = (ph == 4 && op != 0) || (ph == 6 && op == 1 && z);
        ld_pc = ph >= 6 && op == 7;
        ld_ac = ph == 7 && alu;
        wr    = ph == 7 && op == 6;
        de    = ph >= 6 && op == 6;
        hl    = ph == 4 && op == 0;
        if (!r) begin
            ld_ir = 0; inc = 0; ld_pc = 0; ld_ac = 0; wr = 0;
        end
        return {sel, rd, ld_ir, inc, ld_pc, ld_ac, wr, de, hl};
    endfunction

    task automatic step(input int op, input bit z, input bit r, input bit res, input bit rs);
        logic [8:0] exp, got;
        bus.opcode = op[2:0];
        bus.zero   = z;
        bus.run    = r;
        bus.resume = res;
        rst        = rs;
        #2;
        exp = model_out(m_ph, m_halted, op, z, r, res);
        got = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
               bus.ld_ac, bus.wr, bus.data_e, bus.halt};
        chk($sformatf("outputs ph%0d op%0d", m_ph, op), {23'd0, got}, {23'd0, exp});
        chk("phase", {29'd0, bus.phase}, m_ph);
        n_ld_ir += got[6];
        n_inc   += got[5];
        n_ld_pc += got[4];
        n_ld_ac += got[3];
        n_wr    += got[2];
        @(posedge clk);
        #1;
        if (rs) begin
            m_ph = 0; m_halted = 0;
        end else if (m_halted) begin
            if (res) begin m_halted = 0; m_ph = 0; end
        end else if (r) begin
            if (m_ph == 4 && op == 0) m_halted = 1;
            else m_ph = (m_ph + 1) % 8;
        end
    endtask

    task automatic clr_counts();
        n_ld_ir = 0; n_inc = 0; n_ld_ac = 0; n_wr = 0; n_ld_pc = 0;
    endtask

    initial begin
        bus.opcode = 3'd2; bus.zero = 1'b0; bus.run = 1'b0; bus.resume = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_ph = 0; m_halted = 0;
        bus.run = 1'b1; rst = 1'b0;
        #2;
        chk("reset phase", {29'd0, bus.phase}, 32'd0);
        chk("reset outputs", {23'd0, bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc,
                              bus.ld_ac, bus.wr, bus.data_e, bus.halt}, 32'h100);

        // ADD for two full instructions
        clr_counts();
        for (int i = 0; i < 16; i++) step(2, 0, 1, 0, 0);
        chk("add ld_ir count", n_ld_ir, 2);
        chk("add inc_pc count", n_inc, 2);
        chk("add ld_ac count", n_ld_ac, 2);
        chk("add wr count", n_wr, 0);

        clr_counts();
        for (int i = 0; i < 8; i++) step(6, 0, 1, 0, 0);
        chk("sto wr count", n_wr, 1);
        chk("sto ld_ac count", n_ld_ac, 0);

        clr_counts();
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
        chk("skz zero=1 inc count", n_inc, 2);
        clr_counts();
        for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
        chk("skz zero=0 inc count", n_inc, 1);

        clr_counts();
        for (int i = 0; i < 8; i++) step(7, 0, 1, 0, 0);
        chk("jmp ld_pc count", n_ld_pc, 2);
        chk("jmp inc count", n_inc, 1);

        // HLT: reach phase 4, latch halt, sit 10 cycles, resume
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        clr_counts();
        for (int i = 0; i < 10; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0, 0);
        chk("halted inc count", n_inc, 0);
        chk("halted phase", {29'd0, bus.phase}, 32'd4);
        chk("halted halt", {31'd0, bus.halt}, 32'd1);
        step(0, 0, 1, 1, 0);
        chk("resume inc count", n_inc, 1);
        chk("post-resume phase", {29'd0, bus.phase}, 32'd0);
        #2;
        chk("post-resume halt", {31'd0, bus.halt}, 32'd0);

        // Stalls in phases 2 and 7 of an ADD
        clr_counts();
        step(2, 0, 1, 0, 0);
        step(2, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(2, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(2, 0, 0, 0, 0);
        step(2, 0, 1, 0, 0);
        chk("stall ld_ir count", n_ld_ir, 1);
        chk("stall ld_ac count", n_ld_ac, 1);

        // Reset in phase 5
        for (int i = 0; i < 5; i++) step(2, 0, 1, 0, 0);
        chk("pre-reset phase", {29'd0, bus.phase}, 32'd5);
        step(2, 0, 1, 1, 1);
        #2;
        chk("mid reset phase", {29'd0, bus.phase}, 32'd0);
        chk("mid reset sel", {31'd0, bus.sel}, 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 7), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
